// File: rtl/led_pkg.sv
// Shared state encoding and default timing constants for the LED update arbiter.
package led_pkg;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLDOFF   = 2'd3
  } led_state_t;

  localparam int unsigned DEF_HOLDOFF_TICKS = 200000;
  localparam int unsigned DEF_TIMEOUT_TICKS = 1000;
  localparam int          CNT_W             = 32;
endpackage

// File: rtl/led_tick_counter.sv
// 32-bit tick counter with clear, enable and a terminal-count compare.
module led_tick_counter
  import led_pkg::*;
(
  input  logic             CLOCK_5,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] last,
  output logic             terminal
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge CLOCK_5) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 32'd1;
    end
  end

  assign terminal = (count == last);
endmodule

// File: rtl/led_update_arbiter.sv
// Round-robin arbiter feeding two requesters' frame words to one LED serial driver,
// with a driver-done timeout and a minimum holdoff between launches.
module led_update_arbiter
  import led_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned HOLDOFF_TICKS = DEF_HOLDOFF_TICKS,
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic              CLOCK_5,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic              drv_start,
  output logic [DATA_W-1:0] drv_data,
  input  logic              drv_done,
  output logic              busy,
  output logic              last_owner,
  output logic              timeout_err,
  output logic [1:0]        state_dbg
);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  // Handshake: reqN is a level held until ackN; ackN pulses for the single
  // cycle in which dataN is captured, so the requester may drop on the next edge.
  led_state_t       state_q, state_d;
  logic             take, grant, cnt_en, cnt_clear, cnt_term;
  logic [CNT_W-1:0] cnt_last;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    grant   = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          take    = 1'b1;
          // On a tie the requester that did not win last time goes next.
          grant   = (req0 && req1) ? ~last_owner : req1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        cnt_en = 1'b1;
        if (drv_done || cnt_term) state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        cnt_en = 1'b1;
        if (cnt_term) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One counter serves both waits; every state change restarts it from zero.
  assign cnt_clear = (state_q != state_d) || !cnt_en;
  assign cnt_last  = (state_q == ST_HOLDOFF) ? HOLD_LAST : TIMEOUT_LAST;

  led_tick_counter u_tick (
    .CLOCK_5  (CLOCK_5),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .last     (cnt_last),
    .terminal (cnt_term)
  );

  always_ff @(posedge CLOCK_5) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drv_data    <= '0;
      last_owner  <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        drv_data   <= grant ? data1 : data0;
        last_owner <= grant;
      end
      if (state_q == ST_WAIT_DONE) begin
        if (drv_done)      timeout_err <= 1'b0;
        else if (cnt_term) timeout_err <= 1'b1;
      end
    end
  end

  assign ack0      = take && !grant && !reset;
  assign ack1      = take && grant && !reset;
  assign drv_start = (state_q == ST_LAUNCH) && !reset;
  assign busy      = (state_q != ST_IDLE) && !reset;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_led_update_arbiter.sv
// Directed bench for led_update_arbiter with short holdoff/timeout parameters.
module tb_led_update_arbiter;
  localparam int HOLD = 10;
  localparam int TMO  = 16;

  logic       CLOCK_5 = 1'b0;
  logic       reset, req0, req1, drv_done;
  logic [7:0] data0, data1, drv_data;
  logic       ack0, ack1, drv_start, busy, last_owner, timeout_err;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_5 = ~CLOCK_5;

  led_update_arbiter #(.DATA_W(8), .HOLDOFF_TICKS(HOLD), .TIMEOUT_TICKS(TMO)) dut (
    .CLOCK_5(CLOCK_5), .reset(reset), .req0(req0), .data0(data0), .req1(req1),
    .data1(data1), .ack0(ack0), .ack1(ack1), .drv_start(drv_start),
    .drv_data(drv_data), .drv_done(drv_done), .busy(busy),
    .last_owner(last_owner), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  typedef struct {
    logic       rst, r0, r1, done;
    logic [7:0] d0, d1;
    logic       e_ack0, e_ack1, e_start, e_busy, e_owner, e_err;
    logic [7:0] e_data;
    logic [1:0] e_state;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic r0, logic [7:0] d0, logic r1, logic [7:0] d1,
                              logic done, logic a0, logic a1, logic st, logic bz,
                              logic ow, logic er, logic [7:0] dd, logic [1:0] s);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.done = done;
    v.e_ack0 = a0; v.e_ack1 = a1; v.e_start = st; v.e_busy = bz;
    v.e_owner = ow; v.e_err = er; v.e_data = dd; v.e_state = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r0, input logic [7:0] d0,
                       input logic r1, input logic [7:0] d1, input logic done);
    reset = rst; req0 = r0; data0 = d0; req1 = r1; data1 = d1; drv_done = done;
  endtask

  task automatic next_cycle();
    @(posedge CLOCK_5);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    next_cycle();
    next_cycle();
  endtask

  initial begin
    int  cyc, done_at, n_launch;
    int  launch_cyc[4];
    int  grants[4];
    int  n_grant;
    int  both_ack;

    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    next_cycle();
    next_cycle();

    // Single request, then a tie held through HOLDOFF with a stray drv_done.
    tbl.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 0,  0, 0, 0, 0, 1, 0, 8'h00, 2'd0));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 8'h00, 0,  1, 0, 0, 0, 1, 0, 8'h00, 2'd0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 1, 0, 0, 8'hA5, 2'd1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 1, 0, 0, 8'hA5, 2'd2));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 1, 0, 0, 8'hA5, 2'd2));
    tbl.push_back(mk(0, 1, 8'h5A, 1, 8'h3C, 1,  0, 0, 0, 1, 0, 0, 8'hA5, 2'd3));
    for (int k = 0; k < HOLD - 1; k++)
      tbl.push_back(mk(0, 1, 8'h5A, 1, 8'h3C, 0,  0, 0, 0, 1, 0, 0, 8'hA5, 2'd3));
    tbl.push_back(mk(0, 1, 8'h5A, 1, 8'h3C, 0,  0, 1, 0, 0, 0, 0, 8'hA5, 2'd0));
    tbl.push_back(mk(0, 1, 8'h5A, 0, 8'h00, 0,  0, 0, 1, 1, 1, 0, 8'h3C, 2'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1, tbl[i].done);
      @(negedge CLOCK_5);
      chk($sformatf("row%0d_ack0", i), 32'(ack0), 32'(tbl[i].e_ack0));
      chk($sformatf("row%0d_ack1", i), 32'(ack1), 32'(tbl[i].e_ack1));
      chk($sformatf("row%0d_start", i), 32'(drv_start), 32'(tbl[i].e_start));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d_owner", i), 32'(last_owner), 32'(tbl[i].e_owner));
      chk($sformatf("row%0d_err", i), 32'(timeout_err), 32'(tbl[i].e_err));
      chk($sformatf("row%0d_data", i), 32'(drv_data), 32'(tbl[i].e_data));
      chk($sformatf("row%0d_state", i), 32'(state_dbg), 32'(tbl[i].e_state));
      next_cycle();
    end

    // Timeout: drv_done never returned, then a late requester and a good drv_done.
    do_reset();
    drive(0, 1, 8'h11, 0, 8'h00, 0);
    @(negedge CLOCK_5); chk("tmo_ack0", 32'(ack0), 32'd1);
    next_cycle();
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    @(negedge CLOCK_5); chk("tmo_launch", 32'(drv_start), 32'd1);
    next_cycle();
    for (int k = 1; k <= TMO; k++) begin
      @(negedge CLOCK_5);
      chk($sformatf("tmo_wait%0d_err", k), 32'(timeout_err), 32'd0);
      chk($sformatf("tmo_wait%0d_state", k), 32'(state_dbg), 32'd2);
      next_cycle();
    end
    drive(0, 0, 8'h00, 1, 8'h22, 0);
    for (int k = 0; k < HOLD; k++) begin
      drv_done = (k == 1);
      @(negedge CLOCK_5);
      chk($sformatf("tmo_hold%0d_err", k), 32'(timeout_err), 32'd1);
      chk($sformatf("tmo_hold%0d_ack1", k), 32'(ack1), 32'd0);
      chk($sformatf("tmo_hold%0d_state", k), 32'(state_dbg), 32'd3);
      next_cycle();
    end
    drv_done = 1'b0;
    @(negedge CLOCK_5);
    chk("tmo_idle_ack1", 32'(ack1), 32'd1);
    chk("tmo_idle_err", 32'(timeout_err), 32'd1);
    next_cycle();
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    @(negedge CLOCK_5);
    chk("tmo_relaunch", 32'(drv_start), 32'd1);
    chk("tmo_relaunch_data", 32'(drv_data), 32'h22);
    next_cycle();
    drv_done = 1'b1;
    @(negedge CLOCK_5); chk("tmo_done_err_before", 32'(timeout_err), 32'd1);
    next_cycle();
    drv_done = 1'b0;
    @(negedge CLOCK_5);
    chk("tmo_cleared", 32'(timeout_err), 32'd0);
    chk("tmo_cleared_state", 32'(state_dbg), 32'd3);
    next_cycle();

    // Continuous tie: grants alternate, launches spaced HOLD+7 cycles.
    do_reset();
    drive(0, 1, 8'h5A, 1, 8'hC3, 0);
    cyc = 0; done_at = -1; n_launch = 0; n_grant = 0; both_ack = 0;
    while (n_launch < 4 && cyc < 200) begin
      drv_done = (cyc == done_at);
      @(negedge CLOCK_5);
      if (ack0 && ack1) both_ack++;
      if ((ack0 || ack1) && n_grant < 4) begin
        grants[n_grant] = ack1 ? 1 : 0;
        n_grant++;
      end
      if (drv_start) begin
        launch_cyc[n_launch] = cyc;
        chk($sformatf("rr_data%0d", n_launch), 32'(drv_data),
            (n_launch % 2 == 0) ? 32'h5A : 32'hC3);
        n_launch++;
        done_at = cyc + 5;
      end
      next_cycle();
      cyc++;
    end
    chk("rr_launch_count", 32'(n_launch), 32'd4);
    chk("rr_single_ack", 32'(both_ack), 32'd0);
    for (int i = 0; i < n_grant; i++)
      chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    for (int i = 1; i < n_launch; i++)
      chk($sformatf("rr_spacing%0d", i), 32'(launch_cyc[i] - launch_cyc[i-1]), 32'(HOLD + 7));

    // Reset pulse during WAIT_DONE aborts cleanly and restores the first-tie rule.
    do_reset();
    drive(0, 1, 8'h77, 0, 8'h00, 0);
    @(negedge CLOCK_5); chk("rst_ack0", 32'(ack0), 32'd1);
    next_cycle();
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    next_cycle();
    @(negedge CLOCK_5); chk("rst_in_wait", 32'(state_dbg), 32'd2);
    next_cycle();
    drive(1, 1, 8'h77, 1, 8'h88, 0);
    @(negedge CLOCK_5);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(drv_start), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge CLOCK_5);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ack0", 32'(ack0), 32'd1);
    chk("post_rst_ack1", 32'(ack1), 32'd0);
    chk("post_rst_data", 32'(drv_data), 32'h00);
    next_cycle();
    req0 = 1'b0;
    @(negedge CLOCK_5);
    chk("post_rst_start", 32'(drv_start), 32'd1);
    chk("post_rst_launch_data", 32'(drv_data), 32'h77);
    chk("post_rst_owner", 32'(last_owner), 32'd0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
